// File: rtl/rsvs_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rsvs_pkg : shared types and helpers for the reservation station   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package rsvs_pkg;

   localparam int OPCODE_W  = 5;
   localparam int BR_TYPE_W = 3;

   typedef enum logic [BR_TYPE_W-1:0] {
      BR_BEQ  = 3'd0,
      BR_BNE  = 3'd1,
      BR_BLT  = 3'd2,
      BR_BGE  = 3'd3,
      BR_BLTU = 3'd4,
      BR_BGEU = 3'd5,
      BR_JAL  = 3'd6,
      BR_JALR = 3'd7
   } br_type_e;

   // Default-width reference layouts; the station re-declares them at its own XLEN/TAG_W.
   typedef struct packed {
      logic        rdy;
      logic [6:0]  tag;
      logic [31:0] value;
   } rsvs_src_t;

   typedef struct packed {
      logic                 valid;
      logic [OPCODE_W-1:0]  opcode;
      br_type_e             branch_type;
      logic [6:0]           rob_tag;
      rsvs_src_t            rs1;
      rsvs_src_t            rs2;
   } rsvs_entry_t;

   function automatic logic [31:0] f_lowest_onehot(input logic [31:0] i_vec);
      return i_vec & (~i_vec + 32'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rsvs_multi_cdb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rsvs_multi_cdb_if : dispatch, CDB, issue and flush bundle         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface rsvs_multi_cdb_if
   import rsvs_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 7,
   parameter int NUM_CDB = 2,
   parameter int DEPTH   = 8
);
   localparam int c_OCC_W = $clog2(DEPTH) + 1;

   logic                       flush;
   logic                       alloc_valid;
   logic                       alloc_ready;
   logic [OPCODE_W-1:0]        alloc_opcode;
   logic [BR_TYPE_W-1:0]       alloc_branch_type;
   logic [TAG_W-1:0]           alloc_rob_tag;
   logic                       alloc_rs1_rdy;
   logic [XLEN-1:0]            alloc_rs1;
   logic [TAG_W-1:0]           alloc_rs1_tag;
   logic                       alloc_rs2_rdy;
   logic [XLEN-1:0]            alloc_rs2;
   logic [TAG_W-1:0]           alloc_rs2_tag;
   logic [NUM_CDB-1:0]         cdb_valid;
   logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
   logic [NUM_CDB*XLEN-1:0]    cdb_data;
   logic                       issue_valid;
   logic                       issue_ready;
   logic [OPCODE_W-1:0]        issue_opcode;
   logic [BR_TYPE_W-1:0]       issue_branch_type;
   logic [TAG_W-1:0]           issue_rob_tag;
   logic [XLEN-1:0]            issue_rs1;
   logic [XLEN-1:0]            issue_rs2;
   logic [c_OCC_W-1:0]         occupancy;

   modport master (
      output flush, alloc_valid, alloc_opcode, alloc_branch_type, alloc_rob_tag,
             alloc_rs1_rdy, alloc_rs1, alloc_rs1_tag, alloc_rs2_rdy, alloc_rs2,
             alloc_rs2_tag, cdb_valid, cdb_tag, cdb_data, issue_ready,
      input  alloc_ready, issue_valid, issue_opcode, issue_branch_type,
             issue_rob_tag, issue_rs1, issue_rs2, occupancy
   );

   modport slave (
      input  flush, alloc_valid, alloc_opcode, alloc_branch_type, alloc_rob_tag,
             alloc_rs1_rdy, alloc_rs1, alloc_rs1_tag, alloc_rs2_rdy, alloc_rs2,
             alloc_rs2_tag, cdb_valid, cdb_tag, cdb_data, issue_ready,
      output alloc_ready, issue_valid, issue_opcode, issue_branch_type,
             issue_rob_tag, issue_rs1, issue_rs2, occupancy
   );
endinterface
`default_nettype wire

// File: rtl/rsvs_age_select.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rsvs_age_select : age matrix and oldest-eligible one-hot picker   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rsvs_age_select #(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic [DEPTH-1:0] i_alloc_onehot,
   input  logic [DEPTH-1:0] i_free_onehot,
   input  logic [DEPTH-1:0] i_eligible,
   output logic [DEPTH-1:0] o_grant
);
   // r_old[i][j] = 1 : entry i is older than entry j
   logic [DEPTH-1:0] r_old [DEPTH];
   logic [DEPTH-1:0] r_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) r_old[i] <= '0;
      end else if (i_flush) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) r_old[i] <= '0;
      end else begin
         r_valid <= (r_valid & ~i_free_onehot) | i_alloc_onehot;
         for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (i_alloc_onehot[i])
                  r_old[i][j] <= 1'b0;
               else if (i_alloc_onehot[j] && r_valid[i])
                  r_old[i][j] <= 1'b1;
            end
         end
      end
   end

   // Only eligible entries can veto, so stale bits of invalid rows never matter.
   always_comb begin
      o_grant = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_grant[i] = i_eligible[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && i_eligible[j] && r_old[j][i]) o_grant[i] = 1'b0;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/rsvs_multi_cdb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rsvs_multi_cdb : DEPTH-entry reservation station, NUM_CDB wakeup  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rsvs_multi_cdb
   import rsvs_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 8,
   parameter int TAG_W   = 7,
   parameter int NUM_CDB = 2
) (
   input  logic            clk,
   input  logic            rst,
   rsvs_multi_cdb_if.slave bus
);
   localparam int c_OCC_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic             rdy;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  value;
   } src_t;

   typedef struct packed {
      logic                 valid;
      logic [OPCODE_W-1:0]  opcode;
      logic [BR_TYPE_W-1:0] branch_type;
      logic [TAG_W-1:0]     rob_tag;
      src_t                 rs1;
      src_t                 rs2;
   } entry_t;

   entry_t             r_ent [DEPTH];
   entry_t             w_new;
   entry_t             w_sel;
   logic [DEPTH-1:0]   w_valid;
   logic [DEPTH-1:0]   w_free_vec;
   logic [DEPTH-1:0]   w_elig;
   logic [DEPTH-1:0]   w_grant;
   logic [DEPTH-1:0]   w_alloc_oh;
   logic [DEPTH-1:0]   w_free_oh;
   logic [c_OCC_W-1:0] w_occ;
   logic               w_alloc_ready;
   logic               w_issue_valid;
   logic               w_do_alloc;
   logic               w_do_issue;

   // Scanning high-to-low lets the lowest matching channel win.
   function automatic src_t f_wake(input src_t i_src);
      src_t f_res;
      f_res = i_src;
      if (!i_src.rdy) begin
         for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (bus.cdb_valid[c] && (bus.cdb_tag[c*TAG_W +: TAG_W] == i_src.tag)) begin
               f_res.rdy   = 1'b1;
               f_res.value = bus.cdb_data[c*XLEN +: XLEN];
            end
         end
      end
      return f_res;
   endfunction

   always_comb begin
      w_occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_valid[i] = r_ent[i].valid;
         w_elig[i]  = r_ent[i].valid && r_ent[i].rs1.rdy && r_ent[i].rs2.rdy;
         w_occ      = w_occ + c_OCC_W'(r_ent[i].valid);
      end
   end

   assign w_free_vec    = ~w_valid;
   assign w_alloc_ready = |w_free_vec;
   assign w_issue_valid = |w_grant;
   assign w_do_alloc    = bus.alloc_valid && w_alloc_ready && !bus.flush;
   assign w_do_issue    = w_issue_valid && bus.issue_ready && !bus.flush;
   assign w_alloc_oh    = w_do_alloc ? DEPTH'(f_lowest_onehot(32'(w_free_vec))) : '0;
   assign w_free_oh     = w_do_issue ? w_grant : '0;

   always_comb begin
      w_new             = '0;
      w_new.valid       = 1'b1;
      w_new.opcode      = bus.alloc_opcode;
      w_new.branch_type = bus.alloc_branch_type;
      w_new.rob_tag     = bus.alloc_rob_tag;
      w_new.rs1         = f_wake('{rdy: bus.alloc_rs1_rdy, tag: bus.alloc_rs1_tag, value: bus.alloc_rs1});
      w_new.rs2         = f_wake('{rdy: bus.alloc_rs2_rdy, tag: bus.alloc_rs2_tag, value: bus.alloc_rs2});
   end

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_grant[i]) w_sel = r_ent[i];
      end
   end

   rsvs_age_select #(
      .DEPTH (DEPTH)
   ) u_age_select (
      .clk            (clk),
      .rst            (rst),
      .i_flush        (bus.flush),
      .i_alloc_onehot (w_alloc_oh),
      .i_free_onehot  (w_free_oh),
      .i_eligible     (w_elig),
      .o_grant        (w_grant)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      end else if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_free_oh[i]) begin
               r_ent[i].valid <= 1'b0;
            end else if (w_alloc_oh[i]) begin
               r_ent[i] <= w_new;
            end else if (r_ent[i].valid) begin
               r_ent[i].rs1 <= f_wake(r_ent[i].rs1);
               r_ent[i].rs2 <= f_wake(r_ent[i].rs2);
            end
         end
      end
   end

   assign bus.alloc_ready       = w_alloc_ready;
   assign bus.issue_valid       = w_issue_valid;
   assign bus.issue_opcode      = w_sel.opcode;
   assign bus.issue_branch_type = w_sel.branch_type;
   assign bus.issue_rob_tag     = w_sel.rob_tag;
   assign bus.issue_rs1         = w_sel.rs1.value;
   assign bus.issue_rs2         = w_sel.rs2.value;
   assign bus.occupancy         = w_occ;
endmodule
`default_nettype wire

// File: tb/tb_rsvs_multi_cdb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rsvs_multi_cdb : directed self-checking bench for the station  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_rsvs_multi_cdb;
   import rsvs_pkg::*;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   rsvs_multi_cdb_if #(.XLEN(32), .TAG_W(7), .NUM_CDB(2), .DEPTH(8)) bus ();

   rsvs_multi_cdb #(
      .XLEN    (32),
      .DEPTH   (8),
      .TAG_W   (7),
      .NUM_CDB (2)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_alloc(input logic [6:0] tag, input logic r1rdy, input logic [31:0] r1,
                            input logic [6:0] t1, input logic [31:0] r2);
      bus.alloc_valid       = 1'b1;
      bus.alloc_opcode      = 5'h03;
      bus.alloc_branch_type = BR_BNE;
      bus.alloc_rob_tag     = tag;
      bus.alloc_rs1_rdy     = r1rdy;
      bus.alloc_rs1         = r1;
      bus.alloc_rs1_tag     = t1;
      bus.alloc_rs2_rdy     = 1'b1;
      bus.alloc_rs2         = r2;
      bus.alloc_rs2_tag     = 7'h00;
   endtask

   task automatic drv_cdb(input int ch, input logic [6:0] tag, input logic [31:0] data);
      bus.cdb_valid[ch]         = 1'b1;
      bus.cdb_tag[ch*7 +: 7]    = tag;
      bus.cdb_data[ch*32 +: 32] = data;
   endtask

   task automatic idle();
      bus.alloc_valid       = 1'b0;
      bus.alloc_opcode      = '0;
      bus.alloc_branch_type = '0;
      bus.alloc_rob_tag     = '0;
      bus.alloc_rs1_rdy     = 1'b0;
      bus.alloc_rs1         = '0;
      bus.alloc_rs1_tag     = '0;
      bus.alloc_rs2_rdy     = 1'b0;
      bus.alloc_rs2         = '0;
      bus.alloc_rs2_tag     = '0;
      bus.cdb_valid         = '0;
      bus.cdb_tag           = '0;
      bus.cdb_data          = '0;
   endtask

   task automatic chk_issue(input string tag, input logic [6:0] rob);
      chk({tag, "_valid"}, 64'(bus.issue_valid), 64'd1);
      chk({tag, "_tag"}, 64'(bus.issue_rob_tag), 64'(rob));
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.issue_ready = 1'b0;
      idle();
      #10 rst = 1'b0;

      // reset state
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
         chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
         chk("rst_occ", 64'(bus.occupancy), 64'd0);
      end
      chk("rst_issue_tag", 64'(bus.issue_rob_tag), 64'd0);
      chk("rst_issue_rs1", 64'(bus.issue_rs1), 64'd0);

      // ready alloc, one-cycle latency
      bus.issue_ready = 1'b1;
      drv_alloc(7'h11, 1'b1, 32'h5, 7'h00, 32'h7);
      tick();
      idle();
      chk_issue("rdy_issue", 7'h11);
      chk("rdy_opcode", 64'(bus.issue_opcode), 64'h03);
      chk("rdy_brtype", 64'(bus.issue_branch_type), 64'(BR_BNE));
      chk("rdy_rs1", 64'(bus.issue_rs1), 64'h5);
      chk("rdy_rs2", 64'(bus.issue_rs2), 64'h7);
      chk("rdy_occ1", 64'(bus.occupancy), 64'd1);
      tick();
      chk("rdy_occ0", 64'(bus.occupancy), 64'd0);
      chk("rdy_empty", 64'(bus.issue_valid), 64'd0);

      // wakeup on CDB channel 1
      drv_alloc(7'h20, 1'b0, 32'h0, 7'h40, 32'h9);
      tick();
      idle();
      chk("wk_wait_valid", 64'(bus.issue_valid), 64'd0);
      chk("wk_wait_occ", 64'(bus.occupancy), 64'd1);
      tick();
      drv_cdb(0, 7'h41, 32'h1111);
      drv_cdb(1, 7'h40, 32'hDEAD);
      chk("wk_pre_edge", 64'(bus.issue_valid), 64'd0);
      tick();
      idle();
      chk_issue("wk_issue", 7'h20);
      chk("wk_rs1", 64'(bus.issue_rs1), 64'hDEAD);
      chk("wk_rs2", 64'(bus.issue_rs2), 64'h9);
      tick();
      chk("wk_occ0", 64'(bus.occupancy), 64'd0);

      // dispatch bypass: CDB in the allocation cycle
      drv_alloc(7'h21, 1'b0, 32'h0, 7'h40, 32'h9);
      drv_cdb(1, 7'h40, 32'hDEAD);
      tick();
      idle();
      chk_issue("byp_issue", 7'h21);
      chk("byp_rs1", 64'(bus.issue_rs1), 64'hDEAD);
      tick();

      // two channels match: channel 0 wins
      drv_alloc(7'h22, 1'b0, 32'h0, 7'h45, 32'h9);
      tick();
      idle();
      drv_cdb(0, 7'h45, 32'hBEEF);
      drv_cdb(1, 7'h45, 32'hDEAD);
      tick();
      idle();
      chk_issue("prio_issue", 7'h22);
      chk("prio_rs1", 64'(bus.issue_rs1), 64'hBEEF);
      tick();

      // age order: A waiting, B and C ready
      bus.issue_ready = 1'b0;
      drv_alloc(7'h01, 1'b0, 32'h0, 7'h50, 32'h0);
      tick();
      drv_alloc(7'h02, 1'b1, 32'h0, 7'h00, 32'h0);
      tick();
      drv_alloc(7'h03, 1'b1, 32'h0, 7'h00, 32'h0);
      tick();
      idle();
      chk_issue("age_hold_b", 7'h02);
      bus.issue_ready = 1'b1;
      tick();
      chk_issue("age_c", 7'h03);
      tick();
      chk("age_a_waiting", 64'(bus.issue_valid), 64'd0);
      chk("age_occ1", 64'(bus.occupancy), 64'd1);
      drv_cdb(0, 7'h50, 32'hA);
      tick();
      idle();
      chk_issue("age_a", 7'h01);
      chk("age_a_rs1", 64'(bus.issue_rs1), 64'hA);
      tick();
      chk("age_occ0", 64'(bus.occupancy), 64'd0);

      // age order differs from index order: A idx1, B idx0, C idx2
      bus.issue_ready = 1'b0;
      drv_alloc(7'h30, 1'b1, 32'h0, 7'h00, 32'h0);
      tick();
      drv_alloc(7'h04, 1'b1, 32'h0, 7'h00, 32'h0);
      tick();
      idle();
      chk_issue("ord_f", 7'h30);
      bus.issue_ready = 1'b1;
      tick();
      bus.issue_ready = 1'b0;
      drv_alloc(7'h05, 1'b1, 32'h0, 7'h00, 32'h0);
      tick();
      drv_alloc(7'h06, 1'b1, 32'h0, 7'h00, 32'h0);
      tick();
      idle();
      chk_issue("ord_a_hold", 7'h04);
      bus.issue_ready = 1'b1;
      tick();
      chk_issue("ord_b", 7'h05);
      tick();
      chk_issue("ord_c", 7'h06);
      tick();
      chk("ord_empty", 64'(bus.issue_valid), 64'd0);

      // full and backpressure
      bus.issue_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("fill_alloc_ready", 64'(bus.alloc_ready), 64'd1);
         drv_alloc(7'(8'h40 + k), 1'b1, 32'(k), 7'h00, 32'h0);
         tick();
      end
      chk("full_alloc_ready", 64'(bus.alloc_ready), 64'd0);
      chk("full_occ", 64'(bus.occupancy), 64'd8);
      drv_alloc(7'h7F, 1'b1, 32'h0, 7'h00, 32'h0);
      tick();
      idle();
      chk("full_ignored_occ", 64'(bus.occupancy), 64'd8);
      chk_issue("full_oldest", 7'h40);
      bus.issue_ready = 1'b1;
      tick();
      bus.issue_ready = 1'b0;
      chk("bp_occ7", 64'(bus.occupancy), 64'd7);
      chk("bp_alloc_ready", 64'(bus.alloc_ready), 64'd1);
      chk_issue("bp_next", 7'h41);
      drv_alloc(7'h50, 1'b1, 32'h0, 7'h00, 32'h0);
      bus.issue_ready = 1'b1;
      tick();
      idle();
      bus.issue_ready = 1'b0;
      chk("simul_occ", 64'(bus.occupancy), 64'd7);
      chk_issue("simul_next", 7'h42);
      chk("simul_rs1", 64'(bus.issue_rs1), 64'd2);

      // flush with concurrent alloc and issue handshake
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("fl0_occ", 64'(bus.occupancy), 64'd0);
      for (int k = 0; k < 4; k++) begin
         drv_alloc(7'(8'h60 + k), 1'b1, 32'h0, 7'h00, 32'h0);
         tick();
      end
      idle();
      chk("fl_pre_occ", 64'(bus.occupancy), 64'd4);
      bus.flush = 1'b1;
      bus.issue_ready = 1'b1;
      drv_alloc(7'h64, 1'b1, 32'h0, 7'h00, 32'h0);
      tick();
      idle();
      bus.flush = 1'b0;
      bus.issue_ready = 1'b0;
      chk("fl_occ", 64'(bus.occupancy), 64'd0);
      chk("fl_issue_valid", 64'(bus.issue_valid), 64'd0);
      chk("fl_alloc_ready", 64'(bus.alloc_ready), 64'd1);
      chk("fl_issue_tag", 64'(bus.issue_rob_tag), 64'd0);
      tick();
      chk("fl_dropped", 64'(bus.occupancy), 64'd0);
      drv_alloc(7'h65, 1'b1, 32'h0, 7'h00, 32'h0);
      tick();
      idle();
      chk_issue("fl_after", 7'h65);
      chk("fl_after_occ", 64'(bus.occupancy), 64'd1);

      // asynchronous reset between clock edges
      drv_alloc(7'h66, 1'b1, 32'h0, 7'h00, 32'h0);
      tick();
      idle();
      chk("ar_pre_occ", 64'(bus.occupancy), 64'd2);
      #2 rst = 1'b1;
      #1;
      chk("ar_occ", 64'(bus.occupancy), 64'd0);
      chk("ar_issue_valid", 64'(bus.issue_valid), 64'd0);
      chk("ar_alloc_ready", 64'(bus.alloc_ready), 64'd1);
      #2 rst = 1'b0;
      tick();
      chk("ar_after_occ", 64'(bus.occupancy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/rsvs_multi_cdb.md
Name: rsvs_multi_cdb

Overview:
Parametrised reservation station for the OoO engine.
- Buffers DEPTH dispatched ops and captures source operands from NUM_CDB common-data-bus broadcasts.
- Issues the oldest fully-ready op to one functional unit over a valid/ready handshake.
- Sits between rename/dispatch and an ALU or branch unit.
- Successor to the single-entry station: adds depth, multi-CDB wakeup, age ordering and flush.

Parameters:
XLEN, 32, operand/result width
DEPTH, 8, number of entries (power of two, >=2)
TAG_W, 7, ROB/physical tag width (128-entry ROB)
NUM_CDB, 2, number of CDB broadcast channels

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  sync squash of all entries
alloc_valid  in  1  dispatch offers op
alloc_ready  out  1  free entry available
alloc_opcode  in  5  op encoding
alloc_branch_type  in  3  branch subtype
alloc_rob_tag  in  TAG_W  destination tag
alloc_rs1_rdy  in  1  rs1 value valid at dispatch
alloc_rs1  in  XLEN  rs1 value (if rdy)
alloc_rs1_tag  in  TAG_W  rs1 producer tag (if !rdy)
alloc_rs2_rdy / alloc_rs2 / alloc_rs2_tag  in  1/XLEN/TAG_W  same for rs2
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  packed tags, channel 0 in LSBs
cdb_data  in  NUM_CDB*XLEN  packed data, channel 0 in LSBs
issue_valid  out  1  selected op ready
issue_ready  in  1  FU accepts
issue_opcode / issue_branch_type / issue_rob_tag  out  5/3/TAG_W
issue_rs1 / issue_rs2  out  XLEN  captured operands
occupancy  out  clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset (async):
  - All entries invalid; age matrix cleared.
  - alloc_ready=1, issue_valid=0, occupancy=0, all issue_* data outputs 0.
- Entry state: valid, opcode, branch_type, rob_tag, per-source {rdy, tag, value}.
- Allocation:
  - Occurs on alloc_valid&&alloc_ready at a clock edge, into the lowest-index free entry.
  - alloc_ready = occupancy<DEPTH, from registered state only; a same-cycle issue does not free a slot for allocation.
- Wakeup:
  - Each cycle, every valid entry with !rdy compares its tag against each cdb_valid channel.
  - On a match, the value is latched and rdy set at the edge.
  - If more than one channel matches, the lowest channel index wins.
- Dispatch bypass: a source arriving with !rdy whose tag matches a same-cycle CDB broadcast is written as ready with the CDB data. No operand can miss its broadcast.
- Eligibility: valid && rs1.rdy && rs2.rdy, from registered state.
  - Earliest issue of an op allocated ready at edge N, or woken at edge N, is the cycle after edge N (1-cycle min latency).
- Select:
  - Oldest eligible entry by age matrix: old[i][j]=1 means i older than j.
  - On allocation of k: row k cleared, column k set for all currently valid entries.
  - Selection is combinational; issue_* outputs are driven from the selected entry.
  - issue_* outputs hold 0 when issue_valid=0.
- Issue handshake:
  - Entry is freed at the edge where issue_valid&&issue_ready.
  - While issue_ready=0, the selection may change only if an older entry becomes eligible. The FU must sample only on handshake.
- Simultaneous alloc+issue: both take effect; occupancy unchanged. The freed index is not reused in the same cycle.
- Flush:
  - At the edge, all entries are invalidated and the age matrix cleared.
  - alloc and issue in the flush cycle are discarded; occupancy becomes 0.
  - flush has priority over everything except rst.
- Full: alloc_valid with alloc_ready=0 is ignored (no state change).
- Empty: issue_valid=0.
- Reset mid-operation: async clear as above; in-flight handshakes are dropped.

Decomposition:
- Package rsvs_pkg:
  - OPCODE_W=5, BR_TYPE_W=3
  - branch-type enum (BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR)
  - rsvs_src_t struct {rdy, tag, value}
  - rsvs_entry_t struct
- Sub-module rsvs_age_select:
  - Age matrix storage/update plus oldest-eligible one-hot picker.
  - Parametrised by DEPTH; inputs alloc_onehot, free_onehot, flush, eligible vector; output grant one-hot.

Test Plan:
- Reset then idle: rst high 10ns, low. Required: alloc_ready=1, issue_valid=0, occupancy=0 for 5 cycles.
- Ready alloc: alloc op 5'h03, tag 7'h11, rs1=32'h5, rs2=32'h7, both rdy, issue_ready=1. Required: issue_valid the next cycle with rob_tag 7'h11, rs1=5, rs2=7; then occupancy returns to 0.
- Wakeup and bypass:
  - Alloc tag 7'h20 waiting on rs1_tag 7'h40; later, cdb ch1 tag 7'h40 data 32'hDEAD. Required: issue next cycle with issue_rs1=32'hDEAD.
  - Repeat with the CDB in the same cycle as alloc. Required: same result.
- Age order:
  - Alloc A (tag 1, waiting), B (tag 2, ready), C (tag 3, ready); issue_ready=1. Required: B then C issue first.
  - Wake A via CDB. Required: A issues after C.
  - With A, B, C all ready at once, issue order is A, B, C.
- Full/backpressure:
  - Fill 8 entries with issue_ready=0. Required: alloc_ready=0, occupancy=8; a 9th alloc_valid is ignored.
  - Assert issue_ready for 1 cycle. Required: occupancy=7 and alloc_ready=1 next cycle.
- Flush: 4 valid entries, assert flush together with alloc_valid and an issue handshake. Required: next cycle occupancy=0, issue_valid=0, dropped alloc not stored.
